stepper_move_ctrl: RTL

Move sequencer that sits directly upstream of the dual stepper phase driver. It accepts one move command at a time through a valid/ready handshake; each command carries a step count and direction for each of two motors. It drives the driver's two 2-bit direction codes for exactly the commanded number of step periods, then reports completion. The step period matches the driver's phase-advance period, so N commanded steps produce N phase advances.

---
 rtl/stepper_pkg.sv | 21 ++
 rtl/step_tick_gen.sv | 30 +++
 rtl/stepper_move_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared constants for the stepper move sequencer and the phase driver's direction decode.
package stepper_pkg;

    localparam logic [1:0] DIR_STOP = 2'd0;
    localparam logic [1:0] DIR_FWD  = 2'd1;
    localparam logic [1:0] DIR_REV  = 2'd2;

    localparam int unsigned STEP_DIV_DEFAULT = 50000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } move_state_t;

    // Codes 0 and 3 both mean stop; only forward and reverse consume steps.
    function automatic logic dir_is_move(input logic [1:0] dir);
        return (dir == DIR_FWD) || (dir == DIR_REV);
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-period prescaler: counts 0..STEP_DIV-1 and flags the wrap cycle with a one-cycle tick.
module step_tick_gen
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_DIV = STEP_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move sequencer: accepts one two-motor step command, drives direction codes for the
// commanded number of step periods, then pulses done.
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_DIV = STEP_DIV_DEFAULT,
    parameter int unsigned STEP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_dir0,
    input  logic [STEP_W-1:0] cmd_steps0,
    input  logic [1:0]        cmd_dir1,
    input  logic [STEP_W-1:0] cmd_steps1,
    input  logic              abort,
    output logic [1:0]        direccion,
    output logic [1:0]        direccion2,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_left0,
    output logic [STEP_W-1:0] steps_left1
);

    move_state_t       state, state_next;
    logic [STEP_W-1:0] rem0, rem0_next;
    logic [STEP_W-1:0] rem1, rem1_next;
    logic [1:0]        dlat0, dlat0_next;
    logic [1:0]        dlat1, dlat1_next;
    logic [1:0]        dir0_next, dir1_next;
    logic              busy_next, done_next, aborted_next;
    logic              tick_c;

    // Prescaler is held cleared outside RUN so every move starts on a fresh step period.
    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr    (state != ST_RUN),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rem0       <= '0;
            rem1       <= '0;
            dlat0      <= DIR_STOP;
            dlat1      <= DIR_STOP;
            direccion  <= DIR_STOP;
            direccion2 <= DIR_STOP;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_next;
            rem0       <= rem0_next;
            rem1       <= rem1_next;
            dlat0      <= dlat0_next;
            dlat1      <= dlat1_next;
            direccion  <= dir0_next;
            direccion2 <= dir1_next;
            busy       <= busy_next;
            done       <= done_next;
            aborted    <= aborted_next;
        end
    end

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_next   = state;
        rem0_next    = rem0;
        rem1_next    = rem1;
        dlat0_next   = dlat0;
        dlat1_next   = dlat1;
        aborted_next = aborted;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next   = ST_RUN;
                    rem0_next    = dir_is_move(cmd_dir0) ? cmd_steps0 : '0;
                    rem1_next    = dir_is_move(cmd_dir1) ? cmd_steps1 : '0;
                    dlat0_next   = cmd_dir0;
                    dlat1_next   = cmd_dir1;
                    aborted_next = 1'b0;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident final tick.
                if (abort) begin
                    rem0_next    = '0;
                    rem1_next    = '0;
                    aborted_next = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    if (tick_c && (rem0 != '0)) begin
                        rem0_next = rem0 - STEP_W'(1);
                    end
                    if (tick_c && (rem1 != '0)) begin
                        rem1_next = rem1 - STEP_W'(1);
                    end
                    if ((rem0_next == '0) && (rem1_next == '0)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        dir0_next = ((state_next == ST_RUN) && (rem0_next != '0)) ? dlat0_next : DIR_STOP;
        dir1_next = ((state_next == ST_RUN) && (rem1_next != '0)) ? dlat1_next : DIR_STOP;
        busy_next = (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign steps_left0 = rem0;
    assign steps_left1 = rem1;

endmodule
